// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus plus decode handshake and redirect.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            IMemReq_o;
  logic [XLEN-1:0] IMemAddr_o;
  logic            IMemGnt_i;
  logic            IMemRvalid_i;
  logic [XLEN-1:0] IMemRdata_i;
  logic [XLEN-1:0] Instr_o;
  logic [XLEN-1:0] InstrPC_o;
  logic            InstrValid_o;
  logic            InstrReady_i;
  logic            PCsrc_i;
  logic [XLEN-1:0] PCTarget_i;

  modport master (
    output IMemReq_o, IMemAddr_o, Instr_o, InstrPC_o, InstrValid_o,
    input  IMemGnt_i, IMemRvalid_i, IMemRdata_i, InstrReady_i, PCsrc_i, PCTarget_i
  );

  modport slave (
    input  IMemReq_o, IMemAddr_o, Instr_o, InstrPC_o, InstrValid_o,
    output IMemGnt_i, IMemRvalid_i, IMemRdata_i, InstrReady_i, PCsrc_i, PCTarget_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  fetch_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, credit-based request issue, redirect discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [SW-1:0]   inflight;
  logic [XLEN-1:0] target;
  logic            req, gnt, rsp, drop, push, pop, head_valid;
  fetch_entry_t    head;

  assign target   = word_align(bus.PCTarget_i);
  assign pop      = head_valid & bus.InstrReady_i;
  assign inflight = {1'b0, outst_q} + {1'b0, count} - {{(SW-1){1'b0}}, pop};
  // Gated by reset so the request drops immediately on an asynchronous reset.
  assign req      = rst_ni & (inflight < SW'(DEPTH));
  assign gnt      = req & bus.IMemGnt_i;
  assign rsp      = bus.IMemRvalid_i;
  assign drop     = rsp & (discard_q != '0);
  assign push     = rsp & ~drop & ~bus.PCsrc_i;

  assign bus.IMemReq_o    = req;
  assign bus.IMemAddr_o   = (rst_ni & bus.PCsrc_i) ? target : fpc_q;
  assign bus.InstrValid_o = head_valid;
  assign bus.Instr_o      = head_valid ? head.instr : NOP_INSTR;
  assign bus.InstrPC_o    = head_valid ? head.pc : '0;

  always_comb begin
    outst_d   = outst_q + {{(CW-1){1'b0}}, gnt} - {{(CW-1){1'b0}}, rsp};
    discard_d = discard_q - {{(CW-1){1'b0}}, drop};
    fpc_d     = gnt  ? fpc_q + 32'd4 : fpc_q;
    rpc_d     = push ? rpc_q + 32'd4 : rpc_q;
    // Everything still unreturned after this cycle belongs to the old path.
    if (bus.PCsrc_i) begin
      fpc_d     = target;
      rpc_d     = target;
      discard_d = outst_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q     <= RESET_PC;
      rpc_q     <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      rpc_q     <= rpc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i ('{pc: rpc_q, instr: bus.IMemRdata_i}),
    .pop_i   (pop),
    .flush_i (bus.PCsrc_i),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  int          cyc = 0;
  int          lat = 1;
  pend_t       pend[$];
  logic [31:0] grant_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic [31:0] pop_cyc[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC3C3_5A5A;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int i, input logic [31:0] pc, input int c);
    check_eq({tag, "_pc"},    qget(pop_pc, i),  pc);
    check_eq({tag, "_instr"}, qget(pop_ins, i), memf(pc));
    check_eq({tag, "_cyc"},   qget(pop_cyc, i), c);
  endtask

  // One clock cycle: record the pre-edge grant/pop, then present any due response.
  task automatic step();
    #1;
    if (bus.IMemReq_o && bus.IMemGnt_i) begin
      pend.push_back('{bus.IMemAddr_o, cyc + lat});
      grant_log.push_back(bus.IMemAddr_o);
    end
    if (bus.InstrValid_o && bus.InstrReady_i) begin
      pop_pc.push_back(bus.InstrPC_o);
      pop_ins.push_back(bus.Instr_o);
      pop_cyc.push_back(cyc);
      $display("cyc %0d pop pc=%h instr=%h", cyc, bus.InstrPC_o, bus.Instr_o);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.IMemRvalid_i = 1'b1;
      bus.IMemRdata_i  = memf(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.IMemRvalid_i = 1'b0;
      bus.IMemRdata_i  = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_step(input logic [31:0] tgt);
    bus.PCsrc_i    = 1'b1;
    bus.PCTarget_i = tgt;
    step();
    bus.PCsrc_i    = 1'b0;
    bus.PCTarget_i = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_eq({tag, "_req"},   bus.IMemReq_o,    0);
    check_eq({tag, "_addr"},  bus.IMemAddr_o,   32'h0);
    check_eq({tag, "_valid"}, bus.InstrValid_o, 0);
    check_eq({tag, "_instr"}, bus.Instr_o,      32'h13);
    check_eq({tag, "_pc"},    bus.InstrPC_o,    32'h0);
  endtask

  task automatic do_reset(input int latency);
    rst_n            = 1'b0;
    lat              = latency;
    bus.IMemGnt_i    = 1'b1;
    bus.IMemRvalid_i = 1'b0;
    bus.IMemRdata_i  = '0;
    bus.InstrReady_i = 1'b1;
    bus.PCsrc_i      = 1'b0;
    bus.PCTarget_i   = '0;
    pend.delete();
    grant_log.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    bus.IMemGnt_i    = 1'b1;
    bus.IMemRvalid_i = 1'b0;
    bus.IMemRdata_i  = '0;
    bus.InstrReady_i = 1'b1;
    bus.PCsrc_i      = 1'b0;
    bus.PCTarget_i   = '0;
    #1;
    chk_reset_outputs("por");

    // Streaming with 1-cycle memory.
    do_reset(1);
    run(8);
    for (int i = 0; i < 4; i++) chk_pop("stream", i, 32'(4 * i), 2 + i);
    for (int i = 0; i < 6; i++) check_eq("stream_gaddr", qget(grant_log, i), 32'(4 * i));
    check_eq("stream_npop", pop_pc.size(), 6);

    // Back-pressure: exactly DEPTH grants, then resume.
    do_reset(1);
    bus.InstrReady_i = 1'b0;
    run(8);
    #1;
    check_eq("bp_ngrant", grant_log.size(), DEPTH);
    check_eq("bp_req",    bus.IMemReq_o,    0);
    check_eq("bp_valid",  bus.InstrValid_o, 1);
    check_eq("bp_headpc", bus.InstrPC_o,    32'h0);
    bus.InstrReady_i = 1'b1;
    run(6);
    for (int i = 0; i < 4; i++) chk_pop("bp", i, 32'(4 * i), 8 + i);
    check_eq("bp_resume_addr", qget(grant_log, 4), 32'h10);
    chk_pop("bp_resume", 4, 32'h10, 12);

    // Redirect with three words in flight, 3-cycle memory.
    do_reset(3);
    run(2);
    bus.PCsrc_i    = 1'b1;
    bus.PCTarget_i = 32'h100;
    #1;
    check_eq("rd3_addr_comb", bus.IMemAddr_o, 32'h100);
    redirect_step(32'h100);
    run(9);
    chk_pop("rd3", 0, 32'h100, 7);
    chk_pop("rd3", 1, 32'h104, 8);
    chk_pop("rd3", 2, 32'h108, 9);
    check_eq("rd3_npop",   pop_pc.size(), 5);
    check_eq("rd3_gaddr3", qget(grant_log, 3), 32'h100);
    check_eq("rd3_gaddr4", qget(grant_log, 4), 32'h104);

    // Redirect coinciding with a grant, a response and a pop.
    do_reset(1);
    run(2);
    redirect_step(32'h200);
    run(6);
    chk_pop("rdg", 0, 32'h0, 2);
    chk_pop("rdg", 1, 32'h200, 5);
    chk_pop("rdg", 2, 32'h204, 6);
    check_eq("rdg_npop",   pop_pc.size(), 5);
    check_eq("rdg_gaddr2", qget(grant_log, 2), 32'h200);

    // Address wrap; low target bits are ignored.
    do_reset(1);
    run(2);
    redirect_step(32'hFFFF_FFFB);
    run(6);
    chk_pop("wrap", 1, 32'hFFFF_FFF8, 5);
    chk_pop("wrap", 2, 32'hFFFF_FFFC, 6);
    chk_pop("wrap", 3, 32'h0000_0000, 7);
    chk_pop("wrap", 4, 32'h0000_0004, 8);
    check_eq("wrap_gaddr5", qget(grant_log, 5), 32'h0);

    // Asynchronous reset in the middle of a burst.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    do_reset(1);
    run(5);
    chk_pop("rst_restart", 0, 32'h0, 2);
    chk_pop("rst_restart", 1, 32'h4, 3);
    check_eq("rst_gaddr0", qget(grant_log, 0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end. Owns the program counter, issues word reads to instruction memory over a request/grant/response interface, buffers returned words with their PCs in a small queue, and presents them with a valid/ready handshake to the decode stage (the control unit's `Instr_i` source). Branch/jump redirects (`PCsrc`, target) flush the queue and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, queue entries and max (outstanding + buffered) words; power of 2, ≥2
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `IMemReq_o`  out  1  read request
- `IMemAddr_o`  out  32  word-aligned read address, stable while `IMemReq_o`=1 and not granted (except on redirect)
- `IMemGnt_i`  in  1  request accepted this cycle
- `IMemRvalid_i`  in  1  read data valid; responses in request order, ≥1 cycle after grant
- `IMemRdata_i`  in  32  read data
- `Instr_o`  out  32  instruction at queue head
- `InstrPC_o`  out  32  PC of `Instr_o`
- `InstrValid_o`  out  1  head entry valid
- `InstrReady_i`  in  1  decode accepts head (pop when valid & ready)
- `PCsrc_i`  in  1  redirect strobe
- `PCTarget_i`  in  32  redirect target; bits [1:0] forced to 0

## Operation
- Registers: `fpc` (next request address), `rpc` (PC of next accepted response), `outst` (granted, unreturned, 0..DEPTH), `discard` (responses to drop, 0..DEPTH), queue with `count`.
- Credit: `IMemReq_o` = (outst + count − pop) < DEPTH, with pop = `InstrValid_o` & `InstrReady_i`. `IMemAddr_o` = `fpc`.
- Grant: `fpc` += 4 (mod 2^32, wraps to 0), `outst`++.
- Response: `outst`−−. If `discard`>0: drop, `discard`−−. Else push {`rpc`, `IMemRdata_i`}, `rpc` += 4.
- Queue never overflows (credit guarantees space); push and pop same cycle allowed, `count` unchanged.
- Redirect (`PCsrc_i`=1): `fpc` ← `rpc` ← target; queue cleared; `discard` ← outst_next − (non-discarded response this cycle dropped too), i.e. every word granted at or before this cycle and not yet returned is discarded, including a grant in the redirect cycle and any response arriving in it. Pop in the redirect cycle is honoured (consumer already took it). Request address may change in the redirect cycle only.
- `Instr_o` = 32'h0000_0013 (NOP) and `InstrPC_o` = 0 whenever `InstrValid_o`=0.
- Reset (any time, including mid-burst): `IMemReq_o`=0, `IMemAddr_o`=`RESET_PC`, `InstrValid_o`=0, `Instr_o`=NOP, `InstrPC_o`=0, `fpc`=`rpc`=`RESET_PC`, counters 0. Responses for pre-reset requests are not tracked; memory is reset together.

## Timing
- First `IMemReq_o` in first cycle after `rst_ni` deasserts.
- Response at cycle t → `InstrValid_o`=1 at t+1 (registered queue, no bypass).
- Redirect at cycle t → `IMemReq_o` with target address at t+1; earliest target instruction valid at t+3 with 1-cycle memory.
- With 1-cycle memory, always-granting, ready=1 and DEPTH≥4: one instruction per cycle sustained.
- Combinational paths: `InstrReady_i` → `IMemReq_o`; `PCsrc_i`/`PCTarget_i` → `IMemAddr_o`. No path from `IMemRvalid_i` to outputs.

## Structure
- Package `fetch_pkg`: `NOP_INSTR` constant (32'h13), `fetch_entry_t` struct {pc, instr}, `XLEN`=32.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH param, push/pop/flush, count, valid head; flush has priority over push.
- Top: PC/credit/discard logic, instantiates `fetch_fifo`.

## Test plan
- Reset, RESET_PC=0, memory 1-cycle, ready=1 → requests 0,4,8,…; `InstrPC_o` 0,4,8 on consecutive cycles from cycle 3; `Instr_o` matches memory.
- Ready held 0 → exactly DEPTH=4 grants, then `IMemReq_o`=0; ready=1 → four pops, PCs 0..12, requests resume at 16.
- Memory latency 3, redirect to 0x100 with outst=3 → three responses dropped, next valid has `InstrPC_o`=0x100, no stale word ever valid.
- Redirect coinciding with grant and response → both discarded; `discard` returns to 0; stream resumes at target.
- `fpc`=0xFFFF_FFFC → next request address 0x0, `InstrPC_o` wraps identically.
- Assert `rst_ni`=0 mid-burst → all outputs at reset values asynchronously; after release fetch restarts at RESET_PC.
